// File: rtl/ifetch.sv
// Instruction fetch stage: byte PC, word-indexed instruction memory port, one IF/ID register.
// Build option IFETCH_MISALIGN_TRAP_EN: trap on redirects to non-word-aligned targets instead of truncating them.
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign,
  output logic [31:0] fetch_cnt
);

  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_fetch_cnt;
  logic        w_misalign;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_misalign = r_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  assign iaddr     = {2'b00, r_pc[31:2]};
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign misalign  = w_misalign;
  assign fetch_cnt = r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_if_valid  <= 1'b0;
      r_if_pc     <= 32'h0;
      r_if_instr  <= NOP_INSTR;
      r_fetch_cnt <= 32'h0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // A redirect squashes the instruction already in IF/ID, even under stall
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= NOP_INSTR;
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_pc       <= redirect_pc;
      r_misalign <= |redirect_pc[1:0];
`else
      r_pc       <= redirect_pc & 32'hFFFF_FFFC;
`endif
    end else if (stall) begin
      r_pc <= r_pc;
    end else if (w_misalign) begin
      // Trapped: emit bubbles and keep the offending PC until redirected or reset
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= NOP_INSTR;
    end else begin
      r_if_valid  <= 1'b1;
      r_if_pc     <= r_pc;
      r_if_instr  <= idata;
      r_pc        <= r_pc + 32'd4;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: vector table plus hand sequences, results checked through a scoreboard queue.
module tb_ifetch;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] iaddr, idata, if_pc, if_instr, fetch_cnt;
  logic        if_valid, misalign;

  always #5 clk = ~clk;

  ifetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .iaddr(iaddr), .idata(idata), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .misalign(misalign), .fetch_cnt(fetch_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  assign idata = mem_word(iaddr);

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ia;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [31:0] rpc;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc, input logic [31:0] ia,
                              input logic mis, input logic [31:0] cnt);
    vec_t t;
    t.rst = r; t.stl = s; t.rv = rv; t.rpc = rpc;
    t.e.v = v; t.e.pc = pc; t.e.ia = ia; t.e.mis = mis; t.e.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int tag);
    exp_t ex;
    @(negedge clk);
    reset = t.rst; stall = t.stl; redirect_valid = t.rv; redirect_pc = t.rpc;
    sb.push_back(t.e);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    chk("if_valid", tag, {31'b0, if_valid}, {31'b0, ex.v});
    chk("if_pc", tag, if_pc, ex.pc);
    chk("iaddr", tag, iaddr, ex.ia);
    chk("misalign", tag, {31'b0, misalign}, {31'b0, ex.mis});
    chk("fetch_cnt", tag, fetch_cnt, ex.cnt);
    chk("if_instr", tag, if_instr, ex.v ? mem_word({2'b00, ex.pc[31:2]}) : NOP);
  endtask

  vec_t vecs[25];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // rst stl rv rpc | v pc ia mis cnt
    vecs[0]  = mk(1,0,0,0,            0,32'h0,32'h0,0,0);
    vecs[1]  = mk(0,0,0,0,            1,32'h0,32'h1,0,1);
    vecs[2]  = mk(0,0,0,0,            1,32'h4,32'h2,0,2);
    vecs[3]  = mk(0,0,0,0,            1,32'h8,32'h3,0,3);
    vecs[4]  = mk(1,0,0,0,            0,32'h0,32'h0,0,0);
    vecs[5]  = mk(0,0,0,0,            1,32'h0,32'h1,0,1);
    vecs[6]  = mk(0,0,0,0,            1,32'h4,32'h2,0,2);
    vecs[7]  = mk(0,1,0,0,            1,32'h4,32'h2,0,2);
    vecs[8]  = mk(0,1,0,0,            1,32'h4,32'h2,0,2);
    vecs[9]  = mk(0,1,1,32'h100,      0,32'h0,32'h40,0,2);
    vecs[10] = mk(0,0,0,0,            1,32'h100,32'h41,0,3);
    vecs[11] = mk(0,0,0,0,            1,32'h104,32'h42,0,4);
    vecs[12] = mk(0,0,0,0,            1,32'h108,32'h43,0,5);
    vecs[13] = mk(0,1,0,0,            1,32'h108,32'h43,0,5);
    vecs[14] = mk(1,1,1,32'h300,      0,32'h0,32'h0,0,0);
    vecs[15] = mk(0,0,0,0,            1,32'h0,32'h1,0,1);
    vecs[16] = mk(0,0,1,32'hFFFFFFFC, 0,32'h0,32'h3FFFFFFF,0,1);
    vecs[17] = mk(0,0,0,0,            1,32'hFFFFFFFC,32'h0,0,2);
    vecs[18] = mk(0,0,0,0,            1,32'h0,32'h1,0,3);
`ifdef IFETCH_MISALIGN_TRAP_EN
    vecs[19] = mk(0,0,1,32'h102,      0,32'h0,32'h40,1,3);
    vecs[20] = mk(0,0,0,0,            0,32'h0,32'h40,1,3);
    vecs[21] = mk(0,0,0,0,            0,32'h0,32'h40,1,3);
    vecs[22] = mk(0,0,0,0,            0,32'h0,32'h40,1,3);
    vecs[23] = mk(0,0,1,32'h200,      0,32'h0,32'h80,0,3);
    vecs[24] = mk(0,0,0,0,            1,32'h200,32'h81,0,4);
`else
    vecs[19] = mk(0,0,1,32'h102,      0,32'h0,32'h40,0,3);
    vecs[20] = mk(0,0,0,0,            1,32'h100,32'h41,0,4);
    vecs[21] = mk(0,0,0,0,            1,32'h104,32'h42,0,5);
    vecs[22] = mk(0,0,0,0,            1,32'h108,32'h43,0,6);
    vecs[23] = mk(0,0,1,32'h200,      0,32'h0,32'h80,0,6);
    vecs[24] = mk(0,0,0,0,            1,32'h200,32'h81,0,7);
`endif

    for (int i = 0; i < 25; i++) apply(vecs[i], i);

    // Reset, then stall straight out of reset, redirect under stall, release
    apply(mk(1,0,0,0,        0,32'h0,32'h0,0,0), 100);
    apply(mk(0,1,0,0,        0,32'h0,32'h0,0,0), 101);
    apply(mk(0,1,1,32'h40,   0,32'h0,32'h10,0,0), 102);
    apply(mk(0,1,0,0,        0,32'h0,32'h10,0,0), 103);
    apply(mk(0,0,0,0,        1,32'h40,32'h11,0,1), 104);
`ifdef IFETCH_MISALIGN_TRAP_EN
    apply(mk(0,0,1,32'h7,    0,32'h0,32'h1,1,1), 105);
    apply(mk(0,0,0,0,        0,32'h0,32'h1,1,1), 106);
`else
    apply(mk(0,0,1,32'h7,    0,32'h0,32'h1,0,1), 105);
    apply(mk(0,0,0,0,        1,32'h4,32'h2,0,2), 106);
`endif
    apply(mk(1,0,0,0,        0,32'h0,32'h0,0,0), 107);
    apply(mk(0,0,0,0,        1,32'h0,32'h1,0,1), 108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
